// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, requester encoding and writeback payload for the register-bank write port.
package wb_port_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned CNT_WIDTH  = 16;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback request, forwarding and bank write-port signals of the writeback arbiter.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [WORD_WIDTH-1:0] alu_data;
  logic                  alu_ready;

  logic                  lsu_valid;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [WORD_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;

  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic                  fwd1_hit;
  logic                  fwd2_hit;
  logic [WORD_WIDTH-1:0] fwd_data;

  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [WORD_WIDTH-1:0] write_data;

  logic [CNT_WIDTH-1:0]  conflict_cnt;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    input  rs1_addr, rs2_addr,
    output alu_ready, lsu_ready, fwd1_hit, fwd2_hit, fwd_data,
    output write_en, write_addr, write_data, conflict_cnt
  );

  // Writeback sources, read stage and bank side
  modport master (
    output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
    output rs1_addr, rs2_addr,
    input  alu_ready, lsu_ready, fwd1_hit, fwd2_hit, fwd_data,
    input  write_en, write_addr, write_data, conflict_cnt
  );
endinterface

// File: rtl/wb_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on conflict the requester not granted last wins.
module wb_port_arbiter_rr_arbiter2
  import wb_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_lsu,
  output logic gnt_alu_c,
  output logic gnt_lsu_c
);

  wb_src_e last_grant_q;
  wb_src_e last_grant_d;

  // Pointer register, reset so the LSU wins the first conflict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_ALU;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Grant decode and pointer update; no grant is issued while in reset
  always_comb begin
    gnt_alu_c    = 1'b0;
    gnt_lsu_c    = 1'b0;
    last_grant_d = last_grant_q;
    if (!rst) begin
      if (req_alu && req_lsu) begin
        if (last_grant_q == REQ_ALU) begin
          gnt_lsu_c = 1'b1;
        end else begin
          gnt_alu_c = 1'b1;
        end
      end else begin
        gnt_alu_c = req_alu;
        gnt_lsu_c = req_lsu;
      end
      if (gnt_alu_c) begin
        last_grant_d = REQ_ALU;
      end else if (gnt_lsu_c) begin
        last_grant_d = REQ_LSU;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-bank write port between ALU and LSU writeback, with a
// one-deep write stage, read-port forwarding and a conflict-cycle counter.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);

  logic                 gnt_alu;
  logic                 gnt_lsu;
  wb_req_t              sel_req;
  wb_req_t              wr_req_q;
  logic                 wr_valid_q;
  logic [CNT_WIDTH-1:0] conflict_cnt_q;
  logic                 conflict;

  wb_port_arbiter_rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_alu   (bus.alu_valid),
    .req_lsu   (bus.lsu_valid),
    .gnt_alu_c (gnt_alu),
    .gnt_lsu_c (gnt_lsu)
  );

  assign bus.alu_ready = gnt_alu;
  assign bus.lsu_ready = gnt_lsu;
  assign conflict      = bus.alu_valid && bus.lsu_valid;

  // Winner's payload for the write stage
  always_comb begin
    sel_req = '{addr: bus.alu_addr, data: bus.alu_data};
    if (gnt_lsu) begin
      sel_req = '{addr: bus.lsu_addr, data: bus.lsu_data};
    end
  end

  // Write stage: holds the accepted request for exactly one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_valid_q <= 1'b0;
      wr_req_q   <= '0;
    end else begin
      wr_valid_q <= gnt_alu || gnt_lsu;
      if (gnt_alu || gnt_lsu) begin
        wr_req_q <= sel_req;
      end
    end
  end

  // Saturating count of cycles with both sources requesting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_q <= '0;
    end else if (conflict && (conflict_cnt_q != '1)) begin
      conflict_cnt_q <= conflict_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Writes to x0 are accepted but never reach the bank or the forwarding path
  assign bus.write_en     = wr_valid_q && (wr_req_q.addr != '0);
  assign bus.write_addr   = wr_req_q.addr;
  assign bus.write_data   = wr_req_q.data;
  assign bus.fwd1_hit     = wr_valid_q && (wr_req_q.addr == bus.rs1_addr) && (bus.rs1_addr != '0);
  assign bus.fwd2_hit     = wr_valid_q && (wr_req_q.addr == bus.rs2_addr) && (bus.rs2_addr != '0);
  assign bus.fwd_data     = wr_req_q.data;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter against a behavioural writeback model.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  wb_port_arbiter_if bus ();

  wb_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: who was served last, what is in flight, what the bank holds
  int          m_last_lsu;
  bit          m_valid;
  int          m_addr;
  logic [31:0] m_data;
  int          m_cnt;
  logic [31:0] m_bank [32];

  task automatic model_reset();
    m_last_lsu = 0;
    m_valid    = 0;
    m_addr     = 0;
    m_data     = '0;
    m_cnt      = 0;
  endtask

  // Expected readies from the round-robin rule
  task automatic exp_ready(output bit ar, output bit lr);
    ar = 0;
    lr = 0;
    if (!rst) begin
      if (bus.alu_valid && bus.lsu_valid) begin
        if (m_last_lsu != 0) ar = 1; else lr = 1;
      end else begin
        ar = bus.alu_valid;
        lr = bus.lsu_valid;
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs presented this cycle
  task automatic model_edge();
    bit ar, lr;
    if (rst) begin
      model_reset();
      return;
    end
    exp_ready(ar, lr);
    if (m_valid && m_addr != 0) m_bank[m_addr] = m_data;
    if (bus.alu_valid && bus.lsu_valid && m_cnt < 65535) m_cnt++;
    m_valid = ar || lr;
    if (ar) begin
      m_addr = int'(bus.alu_addr); m_data = bus.alu_data; m_last_lsu = 0;
    end else if (lr) begin
      m_addr = int'(bus.lsu_addr); m_data = bus.lsu_data; m_last_lsu = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.lsu_valid = 0; bus.lsu_addr = '0; bus.lsu_data = '0;
    bus.rs1_addr  = '0; bus.rs2_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.alu_valid = 1; bus.lsu_valid = 1; bus.alu_addr = 5'd4; bus.lsu_addr = 5'd4;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd4;
    rst = 1;
    model_reset();
    #1;
    tick();
    tick();
    checks++;
    if (bus.alu_ready !== 1'b0 || bus.lsu_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: alu=%b lsu=%b expected 0 0", bus.alu_ready, bus.lsu_ready);
    end
    checks++;
    if (bus.write_en !== 1'b0 || bus.fwd2_hit !== 1'b0 || bus.conflict_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_outputs: we=%b fwd2=%b cnt=%0d expected 0 0 0",
                         bus.write_en, bus.fwd2_hit, bus.conflict_cnt);
    end
    idle_inputs();
    rst = 0;
    #1;
  endtask

  task automatic test_conflict();
    bit exp_lsu;
    bus.alu_valid = 1; bus.alu_addr = 5'd10; bus.alu_data = 32'h0000_00A1;
    bus.lsu_valid = 1; bus.lsu_addr = 5'd11; bus.lsu_data = 32'h0000_0B01;
    for (int i = 0; i < 4; i++) begin
      exp_lsu = (i % 2 == 0);
      #1;
      checks++;
      if (bus.lsu_ready !== exp_lsu || bus.alu_ready !== !exp_lsu) begin
        errors++; $display("FAIL conflict_grant%0d: alu=%b lsu=%b expected alu=%b lsu=%b",
                           i, bus.alu_ready, bus.lsu_ready, !exp_lsu, exp_lsu);
      end
      tick();
      checks++;
      if (bus.write_addr !== (exp_lsu ? 5'd11 : 5'd10) || bus.write_en !== 1'b1) begin
        errors++; $display("FAIL conflict_write%0d: we=%b addr=%0d expected 1 %0d",
                           i, bus.write_en, bus.write_addr, exp_lsu ? 11 : 10);
      end
    end
    checks++;
    if (bus.conflict_cnt !== 16'd4) begin
      errors++; $display("FAIL conflict_cnt: got %0d expected 4", bus.conflict_cnt);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_alu_only();
    bus.alu_valid = 1; bus.alu_addr = 5'd3; bus.alu_data = 32'h0000_1234;
    #1;
    checks++;
    if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b0) begin
      errors++; $display("FAIL alu_only_ready: alu=%b lsu=%b expected 1 0", bus.alu_ready, bus.lsu_ready);
    end
    tick();
    bus.alu_valid = 0;
    bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd9;
    #1;
    checks++;
    if (bus.write_en !== 1'b1 || bus.write_addr !== 5'd3 || bus.write_data !== 32'h0000_1234) begin
      errors++; $display("FAIL alu_only_write: we=%b addr=%0d data=%h expected 1 3 00001234",
                         bus.write_en, bus.write_addr, bus.write_data);
    end
    checks++;
    if (bus.fwd1_hit !== 1'b1 || bus.fwd2_hit !== 1'b0 || bus.fwd_data !== 32'h0000_1234) begin
      errors++; $display("FAIL alu_only_fwd: hit1=%b hit2=%b data=%h expected 1 0 00001234",
                         bus.fwd1_hit, bus.fwd2_hit, bus.fwd_data);
    end
    tick();
    checks++;
    if (bus.write_en !== 1'b0 || bus.fwd1_hit !== 1'b0) begin
      errors++; $display("FAIL alu_only_drain: we=%b hit1=%b expected 0 0", bus.write_en, bus.fwd1_hit);
    end
    idle_inputs();
  endtask

  task automatic test_x0();
    bus.lsu_valid = 1; bus.lsu_addr = 5'd0; bus.lsu_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (bus.lsu_ready !== 1'b1) begin
      errors++; $display("FAIL x0_ready: lsu=%b expected 1", bus.lsu_ready);
    end
    tick();
    bus.lsu_valid = 0;
    bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
    #1;
    checks++;
    if (bus.write_en !== 1'b0 || bus.fwd1_hit !== 1'b0 || bus.fwd2_hit !== 1'b0) begin
      errors++; $display("FAIL x0_suppress: we=%b hit1=%b hit2=%b expected 0 0 0",
                         bus.write_en, bus.fwd1_hit, bus.fwd2_hit);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_vals [2];
    exp_vals[0] = 32'd1;
    exp_vals[1] = 32'd2;
    bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd7;
    bus.alu_valid = 1; bus.alu_addr = 5'd7; bus.alu_data = 32'd1;
    tick();
    bus.alu_valid = 0;
    bus.lsu_valid = 1; bus.lsu_addr = 5'd7; bus.lsu_data = 32'd2;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (bus.fwd1_hit !== 1'b1 || bus.fwd2_hit !== 1'b1 || bus.fwd_data !== exp_vals[i]) begin
        errors++; $display("FAIL b2b_fwd%0d: hit1=%b hit2=%b data=%0d expected 1 1 %0d",
                           i, bus.fwd1_hit, bus.fwd2_hit, bus.fwd_data, exp_vals[i]);
      end
      checks++;
      if (bus.write_en !== 1'b1 || bus.write_addr !== 5'd7 || bus.write_data !== exp_vals[i]) begin
        errors++; $display("FAIL b2b_write%0d: we=%b addr=%0d data=%0d expected 1 7 %0d",
                           i, bus.write_en, bus.write_addr, bus.write_data, exp_vals[i]);
      end
      if (i == 0) begin
        tick();
        bus.lsu_valid = 0;
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_write();
    bus.alu_valid = 1; bus.alu_addr = 5'd5; bus.alu_data = 32'hA5A5_A5A5;
    tick();
    bus.alu_valid = 0; bus.rs1_addr = 5'd5;
    #1;
    checks++;
    if (bus.write_en !== 1'b1 || bus.write_addr !== 5'd5) begin
      errors++; $display("FAIL midrst_pre: we=%b addr=%0d expected 1 5", bus.write_en, bus.write_addr);
    end
    rst = 1;
    #1;
    checks++;
    if (bus.write_en !== 1'b0 || bus.fwd1_hit !== 1'b0) begin
      errors++; $display("FAIL midrst_drop: we=%b hit1=%b expected 0 0", bus.write_en, bus.fwd1_hit);
    end
    tick();
    rst = 0;
    #1;
    tick();
    checks++;
    if (bus.write_en !== 1'b0 || bus.conflict_cnt !== 16'd0) begin
      errors++; $display("FAIL midrst_after: we=%b cnt=%0d expected 0 0", bus.write_en, bus.conflict_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit ar, lr, hit1, hit2;
    for (int c = 0; c < 400; c++) begin
      bus.rs1_addr = 5'($urandom_range(0, 7));
      bus.rs2_addr = 5'($urandom_range(0, 7));
      #1;
      exp_ready(ar, lr);
      checks++;
      if (bus.alu_ready !== ar || bus.lsu_ready !== lr) begin
        errors++; $display("FAIL rand_ready c%0d: alu=%b lsu=%b expected %b %b",
                           c, bus.alu_ready, bus.lsu_ready, ar, lr);
      end
      hit1 = m_valid && (m_addr == int'(bus.rs1_addr)) && (bus.rs1_addr != 0);
      hit2 = m_valid && (m_addr == int'(bus.rs2_addr)) && (bus.rs2_addr != 0);
      checks++;
      if (bus.fwd1_hit !== hit1 || bus.fwd2_hit !== hit2 || ((hit1 || hit2) && bus.fwd_data !== m_data)) begin
        errors++; $display("FAIL rand_fwd c%0d: hit1=%b hit2=%b data=%h expected %b %b %h",
                           c, bus.fwd1_hit, bus.fwd2_hit, bus.fwd_data, hit1, hit2, m_data);
      end
      checks++;
      if (bus.write_en !== (m_valid && m_addr != 0) ||
          (m_valid && m_addr != 0 && (int'(bus.write_addr) != m_addr || bus.write_data !== m_data))) begin
        errors++; $display("FAIL rand_write c%0d: we=%b addr=%0d data=%h expected addr=%0d data=%h",
                           c, bus.write_en, bus.write_addr, bus.write_data, m_addr, m_data);
      end
      checks++;
      if (int'(bus.conflict_cnt) != m_cnt) begin
        errors++; $display("FAIL rand_cnt c%0d: got %0d expected %0d", c, bus.conflict_cnt, m_cnt);
      end
      tick();
      // A refused requester keeps its request; everyone else draws a fresh one
      if (!(bus.alu_valid && !ar)) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_addr  = 5'($urandom_range(0, 7));
        bus.alu_data  = $urandom;
      end
      if (!(bus.lsu_valid && !lr)) begin
        bus.lsu_valid = 1'($urandom_range(0, 1));
        bus.lsu_addr  = 5'($urandom_range(0, 7));
        bus.lsu_data  = $urandom;
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation();
    rst = 1;
    #1;
    tick();
    rst = 0;
    bus.alu_valid = 1; bus.alu_addr = 5'd1; bus.alu_data = 32'd11;
    bus.lsu_valid = 1; bus.lsu_addr = 5'd2; bus.lsu_data = 32'd22;
    for (int i = 0; i < 65535 - 1; i++) tick();
    checks++;
    if (bus.conflict_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_below: got %h expected fffe", bus.conflict_cnt);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.conflict_cnt !== 16'hFFFF || int'(bus.conflict_cnt) != m_cnt) begin
      errors++; $display("FAIL sat_hold: got %h expected ffff", bus.conflict_cnt);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int r = 0; r < 32; r++) m_bank[r] = '0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_conflict();
    test_alu_only();
    test_x0();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
